// File: rtl/fallback_arbiter.sv
// Round-robin arbiter sharing one host-fallback path between HDU lanes; holds one event and
// mirrors bridge FIFO occupancy. Optional lane-0 priority via HDU_FALLBACK_ARB_PRIO_EN.
module fallback_arbiter #(
  parameter int NUM_LANES         = 4,
  parameter int BRIDGE_DEPTH      = 4,
  parameter int HDU_FUNC_ID_WIDTH = 8,
  parameter int HDU_TOKEN_WIDTH   = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_LANES-1:0]                     req_valid,
  input  logic [NUM_LANES*HDU_FUNC_ID_WIDTH-1:0]   req_func_id,
  input  logic [NUM_LANES*HDU_TOKEN_WIDTH-1:0]     req_token,
  output logic [NUM_LANES-1:0]                     req_ready,
  output logic                                     fail_valid,
  output logic [HDU_FUNC_ID_WIDTH-1:0]             fail_func_id,
  output logic [HDU_TOKEN_WIDTH-1:0]               fail_token,
  input  logic                                     host_ready,
`ifdef HDU_FALLBACK_ARB_PRIO_EN
  input  logic                                     prio_lane0,
`endif
  output logic [$clog2(BRIDGE_DEPTH+1)-1:0]        bridge_occ,
  output logic [$clog2(NUM_LANES)-1:0]             grant_lane
);

  localparam int FW = HDU_FUNC_ID_WIDTH;
  localparam int TW = HDU_TOKEN_WIDTH;
  localparam int LW = $clog2(NUM_LANES);
  localparam int OW = $clog2(BRIDGE_DEPTH + 1);
  localparam logic [OW-1:0] DEPTH_Q = OW'(BRIDGE_DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]    state;
  logic [LW-1:0] rr_ptr;
  logic [LW-1:0] sel;
  logic          found;
  logic          prio_win;
  logic          any_valid;
  logic          pop;
  logic          issue;

  // Lane index k positions above base, wrapped to NUM_LANES (not necessarily a power of two).
  function automatic logic [LW-1:0] lane_at(input logic [LW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_LANES) s = s - NUM_LANES;
    return LW'(s);
  endfunction

  assign any_valid = |req_valid;
  assign pop       = host_ready && (bridge_occ != '0);
  // The bridge cannot push and pop in one cycle, so a host pop always defers the push.
  assign issue     = !rst && (state == HOLD) && !pop && (bridge_occ < DEPTH_Q);
  assign fail_valid = issue;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    sel      = rr_ptr;
    found    = 1'b0;
    prio_win = 1'b0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      if (!found && req_valid[lane_at(rr_ptr, k)]) begin
        found = 1'b1;
        sel   = lane_at(rr_ptr, k);
      end
    end
`ifdef HDU_FALLBACK_ARB_PRIO_EN
    if (prio_lane0 && req_valid[0]) begin
      prio_win = 1'b1;
      sel      = '0;
    end
`endif
  end

  always_comb begin
    req_ready = '0;
    if (!rst && (state == IDLE) && any_valid) req_ready[sel] = 1'b1;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the hold register is small, so it is reset too; fail_func_id/fail_token read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= LW'(NUM_LANES - 1);
      bridge_occ   <= '0;
      grant_lane   <= '0;
      fail_func_id <= '0;
      fail_token   <= '0;
    end else begin
      if (issue)    bridge_occ <= bridge_occ + OW'(1);
      else if (pop) bridge_occ <= bridge_occ - OW'(1);

      case (state)
        IDLE: begin
          if (any_valid) begin
            state        <= HOLD;
            grant_lane   <= sel;
            fail_func_id <= req_func_id[int'(sel)*FW +: FW];
            fail_token   <= req_token[int'(sel)*TW +: TW];
            if (!prio_win) rr_ptr <= sel;
          end
        end
        default: begin
          if (issue) state <= IDLE;
        end
      endcase
    end
  end

endmodule
